// File: rtl/comms_pkg.sv
// Shared types and constants for the comms TX path: state encodings,
// framing bytes and the backoff LFSR step function.
package comms_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WAIT_IDLE = 4'd1,
    ST_DRV_ON    = 4'd2,
    ST_PREAMBLE  = 4'd3,
    ST_SFD       = 4'd4,
    ST_DATA      = 4'd5,
    ST_HOLD      = 4'd6,
    ST_BACKOFF   = 4'd7
  } tx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] LFSR_SEED     = 8'hA5;
  // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form: taps on bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/comms_tx_backoff.sv
// Collision backoff helper: free-running LFSR, retry counter and slot wait
// counter. A start pulse bumps the retry count and loads a random wait of
// (LFSR[3:0] & ((1<<retry)-1)) slots; expired is high once the wait is over.
module comms_tx_backoff
  import comms_pkg::*;
#(
  parameter int SLOT_CYCLES = 256,
  parameter int RETRY_W     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               start,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               expired
);

  // Worst case is 15 slots, so 16 slots of range is always enough.
  localparam int WAIT_W = $clog2(16 * SLOT_CYCLES);

  logic [7:0]         lfsr_q, lfsr_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [3:0]         mask;
  logic [3:0]         slots;

  // Next-state for LFSR, saturating retry counter and wait down-counter.
  always_comb begin
    lfsr_d    = lfsr_step(lfsr_q);
    retry_inc = (retry_q == '1) ? retry_q : retry_q + 1'b1;
    // Bit i of (1<<retry)-1 is set exactly when retry > i.
    for (int i = 0; i < 4; i++) begin
      mask[i] = (32'(retry_inc) > i);
    end
    slots   = lfsr_q[3:0] & mask;
    retry_d = retry_q;
    wait_d  = wait_q;
    if (clear) begin
      retry_d = '0;
    end else if (start) begin
      retry_d = retry_inc;
    end
    if (start) begin
      wait_d = WAIT_W'(slots) * WAIT_W'(SLOT_CYCLES);
    end else if (wait_q != '0) begin
      wait_d = wait_q - 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q  <= LFSR_SEED;
      retry_q <= '0;
      wait_q  <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      retry_q <= retry_d;
      wait_q  <= wait_d;
    end
  end

  assign retry_cnt = retry_q;
  assign expired   = (wait_q == '0);

endmodule

// File: rtl/comms_tx_sequencer.sv
// Manchester TX frame sequencer: waits for an idle line, enables the line
// driver, sends preamble + SFD + tx_len payload bytes from the TX FIFO and
// holds the driver for a few cycles after the last byte.
// Optional feature macro: COMMS_TX_COLLISION_EN (collision retry/backoff).
//
// Encoder handshake: a byte moves when enc_valid & enc_ready are both high
// on a rising clk edge; once enc_valid is raised, it and enc_data hold until
// that transfer, except when the frame is aborted or reset.
module comms_tx_sequencer
  import comms_pkg::*;
#(
  parameter int IFG_CYCLES   = 64,
  parameter int DRV_SETUP    = 8,
  parameter int DRV_HOLD     = 8,
  parameter int PREAMBLE_LEN = 7,
  parameter int SLOT_CYCLES  = 256,
  parameter int MAX_RETRY    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_start,
  input  logic [10:0] tx_len,
  input  logic        line_idle,
  input  logic        collision,
  input  logic        tx_fifo_empty,
  input  logic [7:0]  tx_fifo_dout,
  output logic        tx_fifo_rd_en,
  output logic [7:0]  enc_data,
  output logic        enc_valid,
  input  logic        enc_ready,
  output logic        drvr_en,
  output logic        busy,
  output logic        tx_done,
  output logic        tx_underrun,
  output logic        tx_col_err,
  output logic [3:0]  tx_state
);

  localparam int CNT_W   = 8;
  localparam int RETRY_W = 3;

  tx_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [10:0] len_q, len_d;
  logic        aborted_q, aborted_d;
  logic        done_q, done_d;
  logic        underrun_q, underrun_d;
  logic        col_err_q, col_err_d;
  logic        xfer;

  logic        col_in;
  logic        retry_ok;
  logic        bo_expired;
  logic        bo_start;

`ifdef COMMS_TX_COLLISION_EN
  logic [RETRY_W-1:0] retry_cnt;

  comms_tx_backoff #(
    .SLOT_CYCLES(SLOT_CYCLES),
    .RETRY_W    (RETRY_W)
  ) u_backoff (
    .clk      (clk),
    .rst      (reset),
    .clear    (state_q == ST_IDLE),
    .start    (bo_start),
    .retry_cnt(retry_cnt),
    .expired  (bo_expired)
  );

  assign col_in   = collision;
  // retry_cnt is the value before this collision's increment.
  assign retry_ok = (retry_cnt < RETRY_W'(MAX_RETRY));
`else
  logic unused_col;

  assign col_in     = 1'b0;
  assign retry_ok   = 1'b0;
  assign bo_expired = 1'b1;
  assign unused_col = collision | bo_start;
`endif

  // Encoder byte mux: constant framing bytes, then FWFT FIFO head.
  always_comb begin
    enc_valid = 1'b0;
    enc_data  = 8'h00;
    case (state_q)
      ST_PREAMBLE: begin enc_valid = 1'b1;           enc_data = PREAMBLE_BYTE; end
      ST_SFD:      begin enc_valid = 1'b1;           enc_data = SFD_BYTE;      end
      ST_DATA:     begin enc_valid = ~tx_fifo_empty; enc_data = tx_fifo_dout;  end
      default:     ;
    endcase
  end

  assign xfer          = enc_valid & enc_ready;
  assign tx_fifo_rd_en = xfer & (state_q == ST_DATA);

  // Frame FSM next-state and status pulse computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    aborted_d  = aborted_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    col_err_d  = 1'b0;
    bo_start   = 1'b0;
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          len_d     = (tx_len == 11'd0) ? 11'd1 : tx_len;
          aborted_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (!line_idle) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(IFG_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_DRV_ON;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DRV_ON, ST_PREAMBLE, ST_SFD: begin
        if (col_in) begin
          // Nothing popped yet, so the frame can be retried from scratch.
          bo_start = 1'b1;
          cnt_d    = '0;
          if (retry_ok) begin
            state_d = ST_BACKOFF;
          end else begin
            col_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end else if (state_q == ST_DRV_ON) begin
          if (cnt_q == CNT_W'(DRV_SETUP - 1)) begin
            cnt_d   = '0;
            state_d = ST_PREAMBLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (xfer) begin
          if (state_q == ST_SFD) begin
            byte_cnt_d = '0;
            state_d    = ST_DATA;
          end else if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
            cnt_d   = '0;
            state_d = ST_SFD;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_DATA: begin
        if (col_in) begin
          // Payload already left the FIFO: abort without retry.
          col_err_d = 1'b1;
          aborted_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_HOLD;
        end else if (tx_fifo_empty) begin
          underrun_d = 1'b1;
          aborted_d  = 1'b1;
          cnt_d      = '0;
          state_d    = ST_HOLD;
        end else if (xfer) begin
          if (byte_cnt_q == len_q - 11'd1) begin
            cnt_d   = '0;
            state_d = ST_HOLD;
          end else begin
            byte_cnt_d = byte_cnt_q + 11'd1;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(DRV_HOLD - 1)) begin
          cnt_d   = '0;
          done_d  = ~aborted_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_BACKOFF: begin
        if (bo_expired) begin
          cnt_d   = '0;
          state_d = ST_WAIT_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      aborted_q  <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      col_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      aborted_q  <= aborted_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      col_err_q  <= col_err_d;
    end
  end

  assign drvr_en     = (state_q == ST_DRV_ON) || (state_q == ST_PREAMBLE) ||
                       (state_q == ST_SFD)    || (state_q == ST_DATA)     ||
                       (state_q == ST_HOLD);
  assign busy        = (state_q != ST_IDLE);
  assign tx_done     = done_q;
  assign tx_underrun = underrun_q;
  assign tx_col_err  = col_err_q;
  assign tx_state    = state_q;

endmodule

// File: tb/tb_comms_tx_sequencer.sv
// Bench for comms_tx_sequencer: FWFT FIFO model, encoder byte scoreboard,
// directed frame scenarios. Compile with +define+COMMS_TX_COLLISION_EN to
// exercise the collision/backoff path.
module tb_comms_tx_sequencer;
  import comms_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_start;
  logic [10:0] tx_len;
  logic        line_idle;
  logic        collision;
  logic        tx_fifo_empty;
  logic [7:0]  tx_fifo_dout;
  logic        tx_fifo_rd_en;
  logic [7:0]  enc_data;
  logic        enc_valid;
  logic        enc_ready;
  logic        drvr_en;
  logic        busy;
  logic        tx_done;
  logic        tx_underrun;
  logic        tx_col_err;
  logic [3:0]  tx_state;

  comms_tx_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .tx_start     (tx_start),
    .tx_len       (tx_len),
    .line_idle    (line_idle),
    .collision    (collision),
    .tx_fifo_empty(tx_fifo_empty),
    .tx_fifo_dout (tx_fifo_dout),
    .tx_fifo_rd_en(tx_fifo_rd_en),
    .enc_data     (enc_data),
    .enc_valid    (enc_valid),
    .enc_ready    (enc_ready),
    .drvr_en      (drvr_en),
    .busy         (busy),
    .tx_done      (tx_done),
    .tx_underrun  (tx_underrun),
    .tx_col_err   (tx_col_err),
    .tx_state     (tx_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] fifo_q[$];

  int   drvr_cycles = 0, done_cnt = 0, underrun_cnt = 0, col_cnt = 0;
  int   rd_cnt = 0, backoff_cnt = 0;
  logic pop_pend = 1'b0;
  logic ready_fix = 1'b1;
  bit   ready_rand = 1'b0;
  bit   stab_en = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [3:0] prev_state = 4'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- FIFO / ready driver (after each rising edge) ----------------
  always @(posedge clk) begin
    #2;
    if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
    tx_fifo_empty = (fifo_q.size() == 0);
    tx_fifo_dout  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    enc_ready     = ready_rand ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  // ---------------- monitor / scoreboard (falling edge) ----------------
  always @(negedge clk) begin
    if (reset) begin
      pop_pend   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      pop_pend = tx_fifo_rd_en;
      if (drvr_en) drvr_cycles++;
      if (tx_done) done_cnt++;
      if (tx_underrun) underrun_cnt++;
      if (tx_col_err) col_cnt++;
      if (tx_fifo_rd_en) rd_cnt++;
      if (tx_state == 4'(ST_BACKOFF) && prev_state != 4'(ST_BACKOFF)) backoff_cnt++;
      if (stab_en && prev_stall) begin
        check("stall_valid", enc_valid, 1);
        check("stall_data", enc_data, prev_data);
      end
      if (enc_valid && enc_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL sb_extra observed=%0h expected=none", enc_data);
        end else begin
          check("enc_data", enc_data, exp_q.pop_front());
        end
      end
      prev_stall = enc_valid & ~enc_ready;
      prev_data  = enc_data;
      prev_state = tx_state;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_preamble();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic start_frame(input logic [10:0] len);
    tick(2);
    tx_len   = len;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin
      tick(1);
      n++;
    end
    checks++;
    assert (busy === 1'b0) else begin
      failures++;
      $error("FAIL %s_timeout observed=busy expected=idle within %0d cycles", tag, max);
    end
    tick(2);
  endtask

  int d0, u0, c0, r0, dc0, b0;
  task automatic snap();
    d0 = done_cnt; u0 = underrun_cnt; c0 = col_cnt;
    r0 = rd_cnt; dc0 = drvr_cycles; b0 = backoff_cnt;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    reset = 1'b1; tx_start = 1'b0; tx_len = 11'd0;
    line_idle = 1'b1; collision = 1'b0;

    // Reset values, with tx_start asserted during reset (reset wins).
    tick(3);
    tx_start = 1'b1; tx_len = 11'd5;
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_drvr_en", drvr_en, 0);
    check("rst_enc_valid", enc_valid, 0);
    check("rst_rd_en", tx_fifo_rd_en, 0);
    check("rst_state", tx_state, 4'(ST_IDLE));
    check("rst_done", tx_done, 0);
    check("rst_underrun", tx_underrun, 0);
    check("rst_col_err", tx_col_err, 0);
    reset = 1'b0; tx_start = 1'b0;
    tick(2);
    check("post_rst_busy", busy, 0);

    // Frame 1: len 3, ready always high; a second tx_start while busy is ignored.
    snap();
    push_preamble();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    start_frame(11'd3);
    check("f1_busy", busy, 1);
    tick(5);
    tx_len = 11'd9; tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    wait_idle("f1", 500);
    check("f1_done", done_cnt - d0, 1);
    check("f1_underrun", underrun_cnt - u0, 0);
    check("f1_rd", rd_cnt - r0, 3);
    check("f1_drvr_cycles", drvr_cycles - dc0, 8 + 7 + 1 + 3 + 8);
    check("f1_sb_left", exp_q.size(), 0);
    check("f1_fifo_left", fifo_q.size(), 0);

    // tx_len = 0 behaves as one byte.
    snap();
    push_preamble();
    push_byte(8'h44);
    start_frame(11'd0);
    wait_idle("len0", 500);
    check("len0_done", done_cnt - d0, 1);
    check("len0_rd", rd_cnt - r0, 1);
    check("len0_sb_left", exp_q.size(), 0);

    // Random backpressure: data must hold while stalled; exactly 3 pops.
    snap();
    ready_rand = 1'b1; stab_en = 1'b1;
    push_preamble();
    for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)));
    start_frame(11'd3);
    wait_idle("rnd", 1000);
    ready_rand = 1'b0; stab_en = 1'b0;
    check("rnd_done", done_cnt - d0, 1);
    check("rnd_rd", rd_cnt - r0, 3);
    check("rnd_sb_left", exp_q.size(), 0);

    // Underrun: len 4 with only 2 bytes available.
    snap();
    push_preamble();
    push_byte(8'hA1); push_byte(8'hB2);
    start_frame(11'd4);
    wait_idle("und", 500);
    check("und_underrun", underrun_cnt - u0, 1);
    check("und_done", done_cnt - d0, 0);
    check("und_rd", rd_cnt - r0, 2);
    check("und_state", tx_state, 4'(ST_IDLE));
    check("und_sb_left", exp_q.size(), 0);

    // Line goes busy at cycle 40 of the gap: full 64 idle cycles needed again.
    snap();
    push_preamble();
    push_byte(8'h5A);
    start_frame(11'd1);
    tick(39);
    line_idle = 1'b0;
    tick(5);
    check("ifg_drvr_early", drvr_cycles - dc0, 0);
    line_idle = 1'b1;
    n = 0;
    while (drvr_en !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    check("ifg_idle_cycles", n, 64);
    wait_idle("ifg", 500);
    check("ifg_done", done_cnt - d0, 1);
    check("ifg_sb_left", exp_q.size(), 0);

`ifdef COMMS_TX_COLLISION_EN
    // Five collisions in PREAMBLE: four backoffs then a collision abort.
    snap();
    ready_fix = 1'b0;
    fifo_q.push_back(8'h77);
    start_frame(11'd1);
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (tx_state !== 4'(ST_PREAMBLE) && n < 6000) begin
        tick(1);
        n++;
      end
      check("col_reach_preamble", tx_state, 4'(ST_PREAMBLE));
      collision = 1'b1;
      tick(1);
      collision = 1'b0;
      check("col_drvr_off", drvr_en, 0);
    end
    wait_idle("col", 6000);
    check("col_backoffs", backoff_cnt - b0, 4);
    check("col_err", col_cnt - c0, 1);
    check("col_done", done_cnt - d0, 0);
    check("col_rd", rd_cnt - r0, 0);
    check("col_fifo_kept", fifo_q.size(), 1);
    fifo_q.delete();
    ready_fix = 1'b1;
    tick(2);
`else
    // Without the collision feature, collision is ignored entirely.
    snap();
    collision = 1'b1;
    push_preamble();
    push_byte(8'h66);
    start_frame(11'd1);
    wait_idle("nocol", 500);
    collision = 1'b0;
    check("nocol_done", done_cnt - d0, 1);
    check("nocol_col_err", col_cnt - c0, 0);
    check("nocol_backoffs", backoff_cnt - b0, 0);
`endif

    // Reset in DATA: outputs drop without a clock edge, FIFO untouched.
    push_preamble();
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    start_frame(11'd4);
    n = 0;
    while (tx_state !== 4'(ST_DATA) && n < 300) begin
      tick(1);
      n++;
    end
    check("rstd_reach_data", tx_state, 4'(ST_DATA));
    #2;
    reset = 1'b1;
    #1;
    check("rstd_drvr_en", drvr_en, 0);
    check("rstd_enc_valid", enc_valid, 0);
    check("rstd_busy", busy, 0);
    check("rstd_rd_en", tx_fifo_rd_en, 0);
    check("rstd_fifo_kept", fifo_q.size(), 4);
    check("rstd_sb_pending", exp_q.size(), 4);
    exp_q.delete();
    tick(3);
    reset = 1'b0;
    tick(2);
    snap();
    push_preamble();
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    start_frame(11'd4);
    wait_idle("rstd", 500);
    check("rstd_next_done", done_cnt - d0, 1);
    check("rstd_next_rd", rd_cnt - r0, 4);
    check("rstd_sb_left", exp_q.size(), 0);
    check("rstd_fifo_left", fifo_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
